// File: rtl/axi_write_slave.sv
// AXI3-style write slave: one outstanding AW/W/B transaction into a byte-enabled word memory.
// Optional build macro AXI_WID_CHECK_EN: W beats whose WID differs from the latched AWID are dropped with SLVERR.
module axi_write_slave #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 3,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [WIDTH/8-1:0]       AWID,
   input  logic [WIDTH-1:0]         AWADDR,
   input  logic [WIDTH/8-1:0]       AWLEN,
   input  logic [SIZE-1:0]          AWSIZE,
   input  logic [SIZE-2:0]          AWBURST,
   input  logic                     WVALID,
   output logic                     WREADY,
   input  logic [WIDTH/8-1:0]       WID,
   input  logic [WIDTH-1:0]         WDATA,
   input  logic [WIDTH/8-1:0]       WSTRB,
   input  logic                     WLAST,
   output logic                     BVALID,
   input  logic                     BREADY,
   output logic [WIDTH/8-1:0]       BID,
   output logic [SIZE-2:0]          BRESP,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [WIDTH-1:0]         dbg_data
);
   localparam int NB = WIDTH / 8;
   localparam int AW = $clog2(DEPTH);
   localparam int LB = $clog2(NB);
   localparam int IW = WIDTH - LB;

   localparam logic [SIZE-2:0] BURST_FIXED = (SIZE-1)'(0);
   localparam logic [SIZE-2:0] BURST_INCR  = (SIZE-1)'(1);
   localparam logic [SIZE-2:0] BURST_WRAP  = (SIZE-1)'(2);
   localparam logic [SIZE-2:0] BURST_RSVD  = (SIZE-1)'(3);
   localparam logic [SIZE-2:0] RESP_OKAY   = (SIZE-1)'(0);
   localparam logic [SIZE-2:0] RESP_SLVERR = (SIZE-1)'(2);
   localparam logic [SIZE-2:0] RESP_DECERR = (SIZE-1)'(3);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [NB-1:0]     bid_q, bid_d;
   logic [SIZE-2:0]   bresp_q, bresp_d;
   logic [NB-1:0]     id_q, id_d;
   logic [NB-1:0]     len_q, len_d;
   logic [NB-1:0]     beat_q, beat_d;
   logic [WIDTH-1:0]  addr_q, addr_d;
   logic [SIZE-1:0]   size_q, size_d;
   logic [SIZE-2:0]   burst_q, burst_d;
   logic [SIZE-2:0]   err_q, err_d;
   logic              cfg_bad_q, cfg_bad_d;

   logic              aw_hs, w_hs, b_hs, last_beat;
   logic              aw_size_bad, aw_wrap_len_ok, aw_unaligned, aw_cfg_bad;
   logic [WIDTH-1:0]  aw_align_mask;
   logic [WIDTH-1:0]  step, incr_addr, wrap_mask, addr_next;
   logic [IW-1:0]     word_idx;
   logic              idx_oob, wid_bad, mem_we;
   logic [SIZE-2:0]   beat_resp, err_merged;

   logic [WIDTH-1:0]  mem [DEPTH];

   assign aw_hs     = AWVALID & awready_q;
   assign w_hs      = WVALID & wready_q;
   assign b_hs      = BREADY & bvalid_q;
   assign last_beat = (beat_q == len_q);

   // Burst legality is decided once at the address handshake.
   assign aw_size_bad    = (AWSIZE > SIZE'(LB));
   assign aw_wrap_len_ok = (AWLEN == NB'(1)) || (AWLEN == NB'(3)) ||
                           (AWLEN == NB'(7)) || (AWLEN == NB'(15));
   assign aw_align_mask  = (WIDTH'(1) << AWSIZE) - WIDTH'(1);
   assign aw_unaligned   = ((AWADDR & aw_align_mask) != '0);
   assign aw_cfg_bad     = (AWBURST == BURST_RSVD) || aw_size_bad ||
                           ((AWBURST == BURST_WRAP) && (!aw_wrap_len_ok || aw_unaligned));

   assign step      = WIDTH'(1) << size_q;
   assign incr_addr = addr_q + step;
   assign wrap_mask = ((WIDTH'(len_q) + WIDTH'(1)) << size_q) - WIDTH'(1);

   always_comb begin
      addr_next = incr_addr;
      case (burst_q)
         BURST_FIXED: addr_next = addr_q;
         BURST_INCR:  addr_next = incr_addr;
         BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
         default:     addr_next = incr_addr;
      endcase
   end

   assign word_idx = addr_q[WIDTH-1:LB];
   assign idx_oob  = (word_idx >= IW'(DEPTH));

`ifdef AXI_WID_CHECK_EN
   assign wid_bad = (WID != id_q);
`else
   logic unused_wid;
   assign unused_wid = ^WID;
   assign wid_bad    = 1'b0;
`endif

   assign mem_we = w_hs & ~cfg_bad_q & ~idx_oob & ~wid_bad;

   // Response codes are ordered so that the numeric maximum gives DECERR > SLVERR > OKAY.
   always_comb begin
      beat_resp = RESP_OKAY;
      if (idx_oob)
         beat_resp = RESP_DECERR;
      else if ((WLAST != last_beat) || wid_bad)
         beat_resp = RESP_SLVERR;
      err_merged = (beat_resp > err_q) ? beat_resp : err_q;
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (aw_hs)             state_d = S_DATA;
         S_DATA:  if (w_hs && last_beat) state_d = S_RESP;
         S_RESP:  if (b_hs)              state_d = S_IDLE;
         default:                        state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      awready_d = (state_d == S_IDLE);
      wready_d  = (state_d == S_DATA);
      bvalid_d  = (state_d == S_RESP);
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      id_d      = id_q;
      len_d     = len_q;
      beat_d    = beat_q;
      addr_d    = addr_q;
      size_d    = size_q;
      burst_d   = burst_q;
      err_d     = err_q;
      cfg_bad_d = cfg_bad_q;
      if (aw_hs) begin
         id_d      = AWID;
         addr_d    = AWADDR;
         len_d     = AWLEN;
         size_d    = AWSIZE;
         burst_d   = AWBURST;
         beat_d    = '0;
         cfg_bad_d = aw_cfg_bad;
         err_d     = aw_cfg_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (w_hs) begin
         beat_d = beat_q + NB'(1);
         addr_d = addr_next;
         err_d  = err_merged;
         if (last_beat) begin
            bid_d   = id_q;
            bresp_d = err_merged;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= RESP_OKAY;
         id_q      <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         burst_q   <= BURST_FIXED;
         err_q     <= RESP_OKAY;
         cfg_bad_q <= 1'b0;
      end else begin
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         id_q      <= id_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         err_q     <= err_d;
         cfg_bad_q <= cfg_bad_d;
      end
   end

   // Memory contents survive reset, so this array has no reset branch.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (WSTRB[i])
               mem[word_idx[AW-1:0]][i*8 +: 8] <= WDATA[i*8 +: 8];
         end
      end
   end

   assign dbg_data = mem[dbg_addr];

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BID     = bid_q;
   assign BRESP   = bresp_q;

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed bench for axi_write_slave: a table of whole bursts plus hand sequences
// for reset values, handshake latency, BREADY back-pressure and reset mid-burst.
module tb_axi_write_slave;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [3:0]  AWID = '0;
   logic [31:0] AWADDR = '0;
   logic [3:0]  AWLEN = '0;
   logic [2:0]  AWSIZE = '0;
   logic [1:0]  AWBURST = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [3:0]  WID = '0;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WLAST = 1'b0;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic [5:0]  dbg_addr = '0;
   logic [31:0] dbg_data;

   always #5 clk = ~clk;

   axi_write_slave dut (
      .clk(clk), .reset(reset),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
      .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA),
      .WSTRB(WSTRB), .WLAST(WLAST),
      .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [31:0] data [4];
      logic [3:0]  strb [4];
      logic [3:0]  wlast;
      logic [3:0]  widbad;
      logic [1:0]  exp_resp;
      int          nchk;
      logic [5:0]  chk_idx [4];
      logic [31:0] chk_val [4];
   } vec_t;

   vec_t vt [16];
   int   nv   = 0;
   int   nvec = 0;
   int   nmis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else
         $display("ok   %s: 0x%08h", name, act);
   endtask

   task automatic wait_sig(input int which, input string name, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 64 && !ok; c++) begin
         @(negedge clk);
         case (which)
            0:       ok = AWREADY;
            1:       ok = WREADY;
            default: ok = BVALID;
         endcase
      end
      if (!ok) begin
         nvec++;
         nmis++;
         $display("FAIL %s: timeout, got 0 expected 1", name);
      end
   endtask

   task automatic mem_check(input string name, input logic [5:0] idx, input logic [31:0] exp);
      dbg_addr = idx;
      @(negedge clk);
      check(name, dbg_data, exp);
      @(posedge clk); #1;
   endtask

   task automatic add_vec(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [15:0] strb, input logic [3:0] wlast, input logic [1:0] resp);
      vt[nv].id      = id;
      vt[nv].addr    = addr;
      vt[nv].len     = len;
      vt[nv].size    = size;
      vt[nv].burst   = burst;
      vt[nv].data[0] = d0;
      vt[nv].data[1] = d1;
      vt[nv].data[2] = d2;
      vt[nv].data[3] = d3;
      for (int b = 0; b < 4; b++) vt[nv].strb[b] = strb[b*4 +: 4];
      vt[nv].wlast    = wlast;
      vt[nv].widbad   = 4'h0;
      vt[nv].exp_resp = resp;
      vt[nv].nchk     = 0;
      nv++;
   endtask

   task automatic add_chk(input logic [5:0] idx, input logic [31:0] val);
      vt[nv-1].chk_idx[vt[nv-1].nchk] = idx;
      vt[nv-1].chk_val[vt[nv-1].nchk] = val;
      vt[nv-1].nchk = vt[nv-1].nchk + 1;
   endtask

   task automatic run_burst(input int vi);
      bit         ok;
      logic [3:0] bid_s;
      logic [1:0] bresp_s;
      AWID = vt[vi].id; AWADDR = vt[vi].addr; AWLEN = vt[vi].len;
      AWSIZE = vt[vi].size; AWBURST = vt[vi].burst; AWVALID = 1'b1;
      wait_sig(0, $sformatf("v%0d_aw", vi), ok);
      @(posedge clk); #1;
      AWVALID = 1'b0;
      if (!ok) return;
      for (int b = 0; b <= int'(vt[vi].len); b++) begin
         WID    = vt[vi].id ^ (vt[vi].widbad[b] ? 4'hF : 4'h0);
         WDATA  = vt[vi].data[b];
         WSTRB  = vt[vi].strb[b];
         WLAST  = vt[vi].wlast[b];
         WVALID = 1'b1;
         wait_sig(1, $sformatf("v%0d_w%0d", vi, b), ok);
         @(posedge clk); #1;
         if (!ok) begin
            WVALID = 1'b0;
            return;
         end
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
      BREADY = 1'b1;
      wait_sig(2, $sformatf("v%0d_b", vi), ok);
      bid_s   = BID;
      bresp_s = BRESP;
      @(posedge clk); #1;
      if (!ok) return;
      check($sformatf("v%0d_bid", vi), 32'(bid_s), 32'(vt[vi].id));
      check($sformatf("v%0d_bresp", vi), 32'(bresp_s), 32'(vt[vi].exp_resp));
      for (int k = 0; k < vt[vi].nchk; k++)
         mem_check($sformatf("v%0d_mem%0d", vi, vt[vi].chk_idx[k]), vt[vi].chk_idx[k], vt[vi].chk_val[k]);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int seen;

      // id, addr, len, size, burst, data0..3, strb per beat {b3,b2,b1,b0}, wlast per beat, BRESP
      add_vec(4'h5, 32'h10, 4'd3, 3'd2, 2'b01, 32'h1, 32'h2, 32'h3, 32'h4, 16'hFFFF, 4'b1000, 2'b00);
      add_chk(6'd4, 32'h1); add_chk(6'd5, 32'h2); add_chk(6'd6, 32'h3); add_chk(6'd7, 32'h4);
      add_vec(4'h6, 32'h18, 4'd3, 3'd2, 2'b10, 32'hA, 32'hB, 32'hC, 32'hD, 16'hFFFF, 4'b1000, 2'b00);
      add_chk(6'd6, 32'hA); add_chk(6'd7, 32'hB); add_chk(6'd4, 32'hC); add_chk(6'd5, 32'hD);
      add_vec(4'h7, 32'h08, 4'd1, 3'd2, 2'b00, 32'h1111_2222, 32'h3333_4444, 0, 0, 16'h00C3, 4'b0010, 2'b00);
      add_chk(6'd2, 32'h3333_2222);
      add_vec(4'h1, 32'hFC, 4'd1, 3'd2, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 16'h00FF, 4'b0010, 2'b11);
      add_chk(6'd63, 32'hDEAD_BEEF);
      add_vec(4'h2, 32'h20, 4'd1, 3'd2, 2'b01, 32'h55AA_55AA, 32'h0F0F_0F0F, 0, 0, 16'h00FF, 4'b0010, 2'b00);
      add_chk(6'd8, 32'h55AA_55AA); add_chk(6'd9, 32'h0F0F_0F0F);
      add_vec(4'h3, 32'h20, 4'd1, 3'd2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 16'h00FF, 4'b0010, 2'b10);
      add_chk(6'd8, 32'h55AA_55AA); add_chk(6'd9, 32'h0F0F_0F0F);
      add_vec(4'h4, 32'h20, 4'd0, 3'd3, 2'b01, 32'hFFFF_FFFF, 0, 0, 0, 16'h000F, 4'b0001, 2'b10);
      add_chk(6'd8, 32'h55AA_55AA);
      add_vec(4'h8, 32'h20, 4'd2, 3'd2, 2'b10, 32'hEEEE_EEEE, 32'hEEEE_EEEE, 32'hEEEE_EEEE, 0, 16'h0FFF, 4'b0100, 2'b10);
      add_chk(6'd8, 32'h55AA_55AA); add_chk(6'd9, 32'h0F0F_0F0F);
      add_vec(4'h9, 32'h22, 4'd1, 3'd2, 2'b10, 32'hDDDD_DDDD, 32'hDDDD_DDDD, 0, 0, 16'h00FF, 4'b0010, 2'b10);
      add_chk(6'd8, 32'h55AA_55AA); add_chk(6'd9, 32'h0F0F_0F0F);
      add_vec(4'hB, 32'h100, 4'd0, 3'd2, 2'b11, 32'hCCCC_CCCC, 0, 0, 0, 16'h000F, 4'b0001, 2'b11);
      add_vec(4'hC, 32'h24, 4'd1, 3'd2, 2'b10, 32'h99, 32'h88, 0, 0, 16'h00FF, 4'b0010, 2'b00);
      add_chk(6'd9, 32'h99); add_chk(6'd8, 32'h88);
      add_vec(4'hD, 32'h30, 4'd1, 3'd0, 2'b01, 32'h1122_3344, 32'h0000_BB00, 0, 0, 16'h002F, 4'b0010, 2'b00);
      add_chk(6'd12, 32'h1122_BB44);
      add_vec(4'hE, 32'h40, 4'd1, 3'd2, 2'b01, 32'hA1, 32'hA2, 0, 0, 16'h00FF, 4'b0000, 2'b10);
      add_chk(6'd16, 32'hA1); add_chk(6'd17, 32'hA2);
`ifdef AXI_WID_CHECK_EN
      add_vec(4'hA, 32'h40, 4'd1, 3'd2, 2'b01, 32'hB1, 32'hB2, 0, 0, 16'h00FF, 4'b0010, 2'b10);
      vt[nv-1].widbad = 4'b0010;
      add_chk(6'd16, 32'hB1); add_chk(6'd17, 32'hA2);
`endif

      // Reset values, then AWREADY rises one cycle after release
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 32'(AWREADY), 32'h0);
      check("rst_wready", 32'(WREADY), 32'h0);
      check("rst_bvalid", 32'(BVALID), 32'h0);
      check("rst_bid", 32'(BID), 32'h0);
      check("rst_bresp", 32'(BRESP), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("awready_release_cycle", 32'(AWREADY), 32'h0);
      @(negedge clk);
      check("awready_next_cycle", 32'(AWREADY), 32'h1);
      @(posedge clk); #1;

      // W before AW is held off
      WVALID = 1'b1; WDATA = 32'h5555_5555; WSTRB = 4'hF; WID = 4'h9;
      repeat (3) begin
         @(negedge clk);
         check("w_before_aw_wready", 32'(WREADY), 32'h0);
         @(posedge clk); #1;
      end
      WVALID = 1'b0;

      // Early WLAST with BREADY held low
      BREADY = 1'b0;
      AWID = 4'h9; AWADDR = 32'h50; AWLEN = 4'd2; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
      wait_sig(0, "seqB_aw", ok);
      @(posedge clk); #1;
      AWVALID = 1'b0;
      WVALID = 1'b1; WDATA = 32'hC0; WLAST = 1'b1;
      @(negedge clk);
      check("seqB_wready_t+1", 32'(WREADY), 32'h1);
      @(posedge clk); #1;
      WDATA = 32'hC1; WLAST = 1'b0;
      wait_sig(1, "seqB_w1", ok);
      @(posedge clk); #1;
      WDATA = 32'hC2; WLAST = 1'b1;
      wait_sig(1, "seqB_w2", ok);
      @(posedge clk); #1;
      WVALID = 1'b0; WLAST = 1'b0;
      @(negedge clk);
      check("seqB_bvalid_u+1", 32'(BVALID), 32'h1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("seqB_hold%0d", i), {26'd0, BVALID, BID, BRESP}, {26'd0, 1'b1, 4'h9, 2'b10});
      end
      @(posedge clk); #1;
      BREADY = 1'b1;
      @(posedge clk); #1;
      check("seqB_bvalid_after_hs", 32'(BVALID), 32'h0);
      check("seqB_awready_after_hs", 32'(AWREADY), 32'h1);
      mem_check("seqB_mem20", 6'd20, 32'hC0);
      mem_check("seqB_mem21", 6'd21, 32'hC1);
      mem_check("seqB_mem22", 6'd22, 32'hC2);

      // Reset asserted after two beats of a four-beat burst
      AWID = 4'h3; AWADDR = 32'h60; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
      wait_sig(0, "seqC_aw", ok);
      @(posedge clk); #1;
      AWVALID = 1'b0;
      WID = 4'h3; WVALID = 1'b1; WDATA = 32'hE0; WLAST = 1'b0;
      wait_sig(1, "seqC_w0", ok);
      @(posedge clk); #1;
      WDATA = 32'hE1;
      wait_sig(1, "seqC_w1", ok);
      @(posedge clk); #1;
      WDATA = 32'hE2;
      reset = 1'b0;
      #1;
      check("seqC_wready_in_reset", 32'(WREADY), 32'h0);
      check("seqC_bvalid_in_reset", 32'(BVALID), 32'h0);
      check("seqC_awready_in_reset", 32'(AWREADY), 32'h0);
      WVALID = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (BVALID) seen++;
      end
      check("seqC_no_bvalid", 32'(seen), 32'h0);
      @(posedge clk); #1;
      mem_check("seqC_mem24", 6'd24, 32'hE0);
      mem_check("seqC_mem25", 6'd25, 32'hE1);

      // Table of bursts; the first also confirms a normal AW after the abandoned burst
      for (int vi = 0; vi < nv; vi++) run_burst(vi);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
